tsu_queue_reader: RTL and testbench

Consumer for the timestamp queue read port of a `tsu` instance. It drains 64-bit timestamp entries by watching `q_rd_stat` and issuing `q_rd_en`, buffers them in a small output FIFO, and presents them to the host register or CPU side through a valid/ready handshake. It also provides a flush command that discards queued timestamps, and a delivered-entry counter. It sits in the `q_rd_clk` domain between `tsu` and the host register block.

---
 rtl/tsu_queue_reader.sv | 153 +++++++++++++++
 tb/tb_tsu_queue_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsu_queue_reader.sv
// Drains 64-bit timestamps from the tsu queue read port into a small output FIFO and offers them on a valid/ready port.
// Latency: q_rd_en in cycle N, data on q_rd_data in N+1, ts_valid in N+2; one entry per cycle sustained when ts_ready=1.
// Backpressure: reads stall once buffered + in-flight entries reach BUF_DEPTH; flush drains and drops the tsu queue.
module tsu_queue_reader #(
    parameter int BUF_DEPTH = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 q_rd_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 flush,
    input  logic [7:0]           q_rd_stat,
    input  logic [63:0]          q_rd_data,
    output logic                 q_rd_en,
    output logic                 ts_valid,
    output logic [63:0]          ts_data,
    input  logic                 ts_ready,
    output logic                 flush_busy,
    output logic [CNT_WIDTH-1:0] ts_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [OCC_W:0]   DEPTH_V  = (OCC_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 pend_q, pend_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0] ts_count_q, ts_count_d;
    logic [63:0]          mem_q [BUF_DEPTH];

    logic stat_nz;
    logic room;
    logic rd_req;
    logic push;
    logic pop;
    logic clr;

    assign stat_nz = (q_rd_stat != 8'd0);
    // In-flight read counts against the buffer so a stalled host can never overflow it.
    assign room    = ({1'b0, occ_q} + {{OCC_W{1'b0}}, pend_q}) < DEPTH_V;

    // Sequencer: decides when to pop the tsu queue and whether the returning entry is kept.
    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        push    = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    clr     = 1'b1;
                end else if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Dropping enable stops new reads at once; an in-flight read still lands.
                rd_req = enable & stat_nz & room;
                if (flush) begin
                    state_d = ST_FLUSH;
                    clr     = 1'b1;
                end else begin
                    push = pend_q;
                    if (!enable && !pend_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                // An empty queue means no read is issued now, so any entry arriving this
                // cycle is the last one and is dropped here; nothing is left in flight.
                rd_req = stat_nz;
                if (!stat_nz) begin
                    state_d = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        q_rd_en = rd_req & ~rst;
        pend_d  = q_rd_en;
    end

    // Output buffer bookkeeping and delivered-entry counter.
    always_comb begin
        ts_valid   = (occ_q != '0);
        pop        = ts_valid & ts_ready;
        occ_d      = occ_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        ts_count_d = ts_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        if (clr) begin
            occ_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge q_rd_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            occ_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            ts_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            ts_count_q <= ts_count_d;
        end
    end

    // Buffer storage; contents are only observed through occ, so no reset is needed.
    always_ff @(posedge q_rd_clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= q_rd_data;
        end
    end

    assign ts_data    = ts_valid ? mem_q[rd_ptr_q] : 64'd0;
    assign flush_busy = (state_q == ST_FLUSH);
    assign ts_count   = ts_count_q;

endmodule

// File: tb/tb_tsu_queue_reader.sv
module tb_tsu_queue_reader;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic [7:0]  q_rd_stat;
    logic [63:0] q_rd_data;
    logic        q_rd_en;
    logic        ts_valid;
    logic [63:0] ts_data;
    logic        ts_ready;
    logic        flush_busy;
    logic [15:0] ts_count;

    always #5 clk = ~clk;

    tsu_queue_reader #(.BUF_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .q_rd_clk   (clk),
        .rst        (rst),
        .enable     (enable),
        .flush      (flush),
        .q_rd_stat  (q_rd_stat),
        .q_rd_data  (q_rd_data),
        .q_rd_en    (q_rd_en),
        .ts_valid   (ts_valid),
        .ts_data    (ts_data),
        .ts_ready   (ts_ready),
        .flush_busy (flush_busy),
        .ts_count   (ts_count)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- tsu queue model ----------------
    logic [63:0] tq[$];
    bit          en_lat  = 1'b0;
    bit          started = 1'b0;

    task automatic upd_stat();
        q_rd_stat = (tq.size() > 255) ? 8'd255 : 8'(tq.size());
    endtask

    task automatic tsu_push(input logic [63:0] v);
        tq.push_back(v);
        upd_stat();
    endtask

    // Pop on a sampled q_rd_en; the bus carries junk whenever no read was issued.
    always @(posedge clk) begin
        #1;
        if (en_lat && tq.size() != 0) q_rd_data = tq.pop_front();
        else                          q_rd_data = {$urandom, $urandom};
        upd_stat();
    end

    // ---------------- reference model and per-cycle compare ----------------
    int          m_st   = 0;     // 0 idle, 1 run, 2 flush
    bit          m_pend = 1'b0;
    logic [63:0] m_buf[$];
    logic [15:0] m_cnt  = 16'd0;
    int          hs_total = 0;
    int          rd_total = 0;
    logic [63:0] hs_q[$];

    always @(negedge clk) begin
        bit          e_valid;
        bit          e_en;
        logic [63:0] e_data;
        en_lat = (q_rd_en === 1'b1);
        if (started) begin
            e_valid = (m_buf.size() != 0);
            e_data  = e_valid ? m_buf[0] : 64'd0;
            if (rst)            e_en = 1'b0;
            else if (m_st == 1) e_en = enable && (q_rd_stat != 0) && (m_buf.size() + int'(m_pend) < DEPTH);
            else if (m_st == 2) e_en = (q_rd_stat != 0);
            else                e_en = 1'b0;
            chk("m_ts_valid",   ts_valid,   e_valid);
            chk("m_ts_data",    ts_data,    e_data);
            chk("m_q_rd_en",    q_rd_en,    e_en);
            chk("m_flush_busy", flush_busy, (m_st == 2));
            chk("m_ts_count",   ts_count,   m_cnt);
            if (q_rd_en) rd_total++;
            if (!rst && ts_valid && ts_ready) begin
                hs_total++;
                hs_q.push_back(ts_data);
            end
            if (rst) begin
                m_st = 0; m_pend = 1'b0; m_buf.delete(); m_cnt = 16'd0;
            end else begin
                if (e_valid && ts_ready) begin
                    void'(m_buf.pop_front());
                    m_cnt++;
                end
                case (m_st)
                    0: begin
                        if (flush) begin m_st = 2; m_buf.delete(); end
                        else if (enable) m_st = 1;
                    end
                    1: begin
                        if (flush) begin m_st = 2; m_buf.delete(); end
                        else begin
                            if (m_pend) m_buf.push_back(q_rd_data);
                            if (!enable && !m_pend) m_st = 0;
                        end
                    end
                    default: begin
                        if (q_rd_stat == 0) m_st = enable ? 1 : 0;
                    end
                endcase
                m_pend = e_en;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic at_drive();
        @(posedge clk);
        #2;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int nb;
        int r0;
        int h0;
        int target;
        logic [15:0] c0;
        rst = 1'b1; enable = 1'b0; flush = 1'b0; ts_ready = 1'b0;
        q_rd_stat = 8'd0; q_rd_data = 64'd0;
        @(posedge clk);
        started = 1'b1;
        tick();
        chk("rst_q_rd_en", q_rd_en, 0);
        chk("rst_ts_valid", ts_valid, 0);
        chk("rst_ts_data", ts_data, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_ts_count", ts_count, 0);

        // T1: three entries streamed with ts_ready held high
        at_drive();
        rst = 1'b0; enable = 1'b1; ts_ready = 1'b1;
        tsu_push(64'h1); tsu_push(64'h2); tsu_push(64'h3);
        n = 0;
        tick();
        while (!q_rd_en && n < 10) begin tick(); n++; end
        chk("t1_first_rd_latency", n, 1);
        tick(); chk("t1_rd2", q_rd_en, 1);
        tick(); chk("t1_rd3", q_rd_en, 1); chk("t1_data1", ts_data, 64'h1);
        tick(); chk("t1_rd_stop", q_rd_en, 0); chk("t1_data2", ts_data, 64'h2);
        tick(); chk("t1_data3", ts_data, 64'h3);
        tick(); chk("t1_valid_low", ts_valid, 0); chk("t1_count", ts_count, 16'd3);

        // T2: backpressure with five queued
        at_drive();
        ts_ready = 1'b0; r0 = rd_total;
        for (int i = 0; i < 5; i++) tsu_push(64'h10 + 64'(i));
        tick();
        for (int i = 0; i < 9; i++) tick();
        chk("t2_reads", rd_total - r0, 3);
        chk("t2_stat", q_rd_stat, 2);
        chk("t2_valid", ts_valid, 1);
        chk("t2_head_held", ts_data, 64'h10);
        at_drive();
        ts_ready = 1'b1; h0 = hs_q.size();
        n = 0;
        tick();
        while (hs_q.size() < h0 + 5 && n < 30) begin tick(); n++; end
        chk("t2_all_delivered", hs_q.size() - h0, 5);
        for (int i = 0; i < 5; i++) begin
            if (hs_q.size() > h0 + i) chk("t2_order", hs_q[h0+i], 64'h10 + 64'(i));
        end

        // T3: flush with two entries buffered and one in flight
        at_drive();
        ts_ready = 1'b0; h0 = hs_total; c0 = ts_count;
        for (int i = 0; i < 4; i++) tsu_push(64'h20 + 64'(i));
        tick(); tick(); tick();
        chk("t3_buffered", ts_valid, 1);
        at_drive(); flush = 1'b1;
        tick();
        at_drive(); flush = 1'b0;
        tick();
        chk("t3_valid_dropped", ts_valid, 0);
        nb = 0;
        while (flush_busy && nb < 20) begin nb++; tick(); end
        chk("t3_busy_cycles", nb, 2);
        chk("t3_stat_empty", q_rd_stat, 0);
        repeat (4) tick();
        chk("t3_no_hs", hs_total - h0, 0);
        chk("t3_count_kept", ts_count, c0);
        chk("t3_count_literal", ts_count, 16'd8);

        // T4: enable dropped right after a read is issued
        at_drive();
        ts_ready = 1'b1; r0 = rd_total; h0 = hs_q.size();
        tsu_push(64'h40); tsu_push(64'h41); tsu_push(64'h42);
        n = 0;
        tick();
        while (!q_rd_en && n < 10) begin tick(); n++; end
        at_drive(); enable = 1'b0;
        repeat (6) tick();
        chk("t4_one_read", rd_total - r0, 1);
        chk("t4_delivered", hs_q.size() - h0, 1);
        if (hs_q.size() > h0) chk("t4_entry", hs_q[h0], 64'h40);
        chk("t4_stat", q_rd_stat, 2);
        chk("t4_valid_low", ts_valid, 0);
        at_drive(); enable = 1'b1;
        n = 0;
        tick();
        while (!q_rd_en && n < 10) begin tick(); n++; end
        chk("t4_idle_restart", n, 1);

        // T5: ts_count wrap
        n = 0;
        while ((q_rd_stat != 0 || ts_valid) && n < 20) begin tick(); n++; end
        target = hs_total + ((16'hFFFE - (hs_total % 65536) + 65536) % 65536);
        for (int i = hs_total; i < target; i++) tsu_push(64'(i));
        n = 0;
        while (hs_total < target && n < 70000) begin tick(); n++; end
        chk("t5_preset", ts_count, 16'hFFFE);
        at_drive();
        ts_ready = 1'b0;
        tsu_push(64'hA0); tsu_push(64'hA1); tsu_push(64'hA2);
        repeat (5) tick();
        at_drive(); ts_ready = 1'b1;
        tick(); chk("t5_cnt_fffe", ts_count, 16'hFFFE);
        tick(); chk("t5_cnt_ffff", ts_count, 16'hFFFF);
        tick(); chk("t5_cnt_0000", ts_count, 16'h0000);
        tick(); chk("t5_cnt_0001", ts_count, 16'h0001);

        // T6: reset with one read in flight and two buffered
        at_drive();
        ts_ready = 1'b0;
        for (int i = 0; i < 5; i++) tsu_push(64'h60 + 64'(i));
        tick(); tick(); tick();
        at_drive(); rst = 1'b1;
        tick();
        at_drive(); rst = 1'b0; ts_ready = 1'b1; h0 = hs_q.size();
        tick();
        chk("t6_q_rd_en", q_rd_en, 0);
        chk("t6_ts_valid", ts_valid, 0);
        chk("t6_ts_data", ts_data, 0);
        chk("t6_flush_busy", flush_busy, 0);
        chk("t6_ts_count", ts_count, 0);
        n = 0;
        while (hs_q.size() == h0 && n < 20) begin tick(); n++; end
        chk("t6_delivered", hs_q.size() > h0, 1);
        if (hs_q.size() > h0) chk("t6_next_entry", hs_q[h0], 64'h63);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            at_drive();
            enable   = ($urandom_range(0, 9) != 0);
            ts_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 40) == 0);
            rst      = ($urandom_range(0, 400) == 0);
            if ($urandom_range(0, 2) == 0) tsu_push({$urandom, $urandom});
            tick();
        end
        at_drive();
        rst = 1'b0; flush = 1'b0; enable = 1'b1; ts_ready = 1'b1;
        repeat (300) tick();
        chk("final_drained", ts_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
